// File: rtl/fft8_in_buffer.sv
// Ping-pong input buffer for the 8-point FFT: packs a serial sample stream into 8-lane frames.
// Define FFT_IN_BITREV_EN to present lanes in bit-reversed sample order; otherwise lanes are in natural order.
module fft8_in_buffer #(
    parameter int DW = 9,
    parameter int N  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   s_data,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic            s_last,
    output logic [N*DW-1:0] m_frame,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            err,
    output logic [7:0]      err_cnt
);

    localparam logic [2:0] LAST_IDX = 3'(N - 1);

    logic [DW-1:0] mem [0:1][0:N-1];
    logic [2:0]    wr_idx;
    logic          wr_bank;
    logic          rd_bank;
    logic [1:0]    full;
    logic          accept;
    logic          rel_frame;

    // Output lane k is fed from this slot of the read bank.
    function automatic logic [2:0] lane_src(input logic [2:0] k);
`ifdef FFT_IN_BITREV_EN
        return {k[0], k[1], k[2]};
`else
        return k;
`endif
    endfunction

    // Gating with rst keeps s_ready low during reset, before the flags are cleared.
    assign s_ready   = !rst && !full[wr_bank];
    assign m_valid   = full[rd_bank];
    assign accept    = s_valid && s_ready;
    assign rel_frame = m_valid && m_ready;

    // NOTE: sample storage is deliberately left unreset; the full flags alone decide what is visible.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_bank][wr_idx] <= s_data;
        end
    end

    // A completing write and a release always target different banks, so both may update full.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx  <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            full    <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= 1'b0;
            if (accept) begin
                if (wr_idx == LAST_IDX) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    wr_idx        <= '0;
                end else if (s_last) begin
                    wr_idx <= '0;
                    err    <= 1'b1;
                    if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                end else begin
                    wr_idx <= wr_idx + 3'd1;
                end
            end
            if (rel_frame) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

    // NOTE: default-assign before the loop so every bit is written on every path (no latch).
    always_comb begin
        m_frame = '0;
        if (m_valid) begin
            for (int k = 0; k < N; k++) begin
                m_frame[DW*k +: DW] = mem[rd_bank][lane_src(3'(k))];
            end
        end
    end

endmodule

// File: tb/tb_fft8_in_buffer.sv
// Self-checking bench for fft8_in_buffer: directed tables and sequences plus random traffic
// compared against a frame-queue reference model.
module tb_fft8_in_buffer;

    logic        clk;
    logic        rst;
    logic [8:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic [71:0] m_frame;
    logic        m_valid;
    logic        m_ready;
    logic        err;
    logic [7:0]  err_cnt;

    fft8_in_buffer dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .s_last(s_last), .m_frame(m_frame), .m_valid(m_valid), .m_ready(m_ready),
        .err(err), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    // Reference model: completed frames in arrival order, plus the partial frame being collected.
    logic [8:0]  part[$];
    logic [71:0] fq[$];
    logic        e_err = 1'b0;
    int          e_cnt = 0;

    // Observed values and event counters for the directed sequences.
    logic obs_ready, obs_valid;
    logic [71:0] obs_frame;
    int err_seen, valid_seen, ready_low;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int src_of(input int k);
`ifdef FFT_IN_BITREV_EN
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
`else
        return k;
`endif
    endfunction

    function automatic logic [71:0] lanes(input logic [71:0] f);
        logic [71:0] o;
        o = '0;
        for (int k = 0; k < 8; k++) o[9*k +: 9] = f[9*src_of(k) +: 9];
        return o;
    endfunction

    // One clock cycle: drive, compare at the falling edge, then advance the model at the rising edge.
    task automatic cycle(input logic sv, input logic [8:0] sd, input logic sl, input logic mr,
                         input logic r, output logic acc);
        logic e_ready, e_valid, rel;
        logic [71:0] e_frame, f;
        s_valid = sv; s_data = sd; s_last = sl; m_ready = mr; rst = r;
        @(negedge clk);
        e_ready = !r && (fq.size() < 2);
        e_valid = fq.size() > 0;
        e_frame = e_valid ? lanes(fq[0]) : '0;
        obs_ready = s_ready; obs_valid = m_valid; obs_frame = m_frame;
        check("s_ready", 72'(s_ready), 72'(e_ready));
        if (!r) begin
            check("m_valid", 72'(m_valid), 72'(e_valid));
            check("m_frame", m_frame, e_frame);
            check("err", 72'(err), 72'(e_err));
            check("err_cnt", 72'(err_cnt), 72'(e_cnt));
            if (err) err_seen++;
            if (m_valid) valid_seen++;
            if (!s_ready) ready_low++;
        end
        acc = sv && e_ready;
        rel = e_valid && mr && !r;
        @(posedge clk);
        if (r) begin
            fq.delete(); part.delete(); e_err = 1'b0; e_cnt = 0;
        end else begin
            e_err = 1'b0;
            if (rel) void'(fq.pop_front());
            if (acc) begin
                part.push_back(sd);
                if (part.size() == 8) begin
                    f = '0;
                    for (int j = 0; j < 8; j++) f[9*j +: 9] = part[j];
                    fq.push_back(f);
                    part.delete();
                end else if (sl) begin
                    part.delete();
                    e_err = 1'b1;
                    if (e_cnt < 255) e_cnt++;
                end
            end
        end
        #1;
    endtask

    // Hold one sample on the input until it is accepted, with a bounded wait.
    task automatic send(input logic [8:0] v, input logic sl, input logic mr);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) cycle(1'b1, v, sl, mr, 1'b0, acc);
        if (!acc) check("send_timeout", 72'(0), 72'(1));
    endtask

    task automatic idle(input int n, input logic mr);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 9'd0, 1'b0, mr, 1'b0, acc);
    endtask

    task automatic clear_counts();
        err_seen = 0; valid_seen = 0; ready_low = 0;
    endtask

    typedef struct {
        logic       sv;
        logic [8:0] sd;
        logic       mr;
        logic       e_ready;
        logic       e_valid;
    } vec_t;

    initial begin
        vec_t tbl[10];
        int   t1[8];
        logic [71:0] exp1;
        logic acc;

        for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 9'(1 << i), 1'b1, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 9'd0, 1'b1, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 9'd0, 1'b1, 1'b1, 1'b0};
`ifdef FFT_IN_BITREV_EN
        t1 = '{1, 16, 4, 64, 2, 32, 8, 128};
`else
        t1 = '{1, 2, 4, 8, 16, 32, 64, 128};
`endif
        exp1 = '0;
        for (int k = 0; k < 8; k++) exp1[9*k +: 9] = 9'(t1[k]);

        s_valid = 0; s_data = 0; s_last = 0; m_ready = 0; rst = 1;
        cycle(1'b0, 9'd0, 1'b0, 1'b0, 1'b1, acc);
        cycle(1'b0, 9'd0, 1'b0, 1'b0, 1'b1, acc);

        // Powers of two back to back; frame visible for one cycle after the 8th accept.
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].sv, tbl[i].sd, 1'b0, tbl[i].mr, 1'b0, acc);
            check("t1_ready", 72'(obs_ready), 72'(tbl[i].e_ready));
            check("t1_valid", 72'(obs_valid), 72'(tbl[i].e_valid));
            if (i == 8) check("t1_frame", obs_frame, exp1);
        end

        // Back-pressure: both banks fill, then one release frees a bank.
        for (int v = 0; v < 16; v++) send(9'(v), 1'b0, 1'b0);
        cycle(1'b1, 9'd16, 1'b0, 1'b0, 1'b0, acc);
        check("t2_stall", 72'(obs_ready), 72'(0));
        cycle(1'b1, 9'd16, 1'b0, 1'b1, 1'b0, acc);
        cycle(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, acc);
        check("t2_freed", 72'(obs_ready), 72'(1));
        idle(3, 1'b1);

        // Early s_last aborts the partial frame.
        clear_counts();
        for (int i = 0; i < 5; i++) send(9'(i + 50), i == 4, 1'b1);
        for (int i = 0; i < 8; i++) send(9'(100 + i), 1'b0, 1'b1);
        idle(3, 1'b1);
        check("t3_err_pulses", 72'(err_seen), 72'(1));
        check("t3_err_cnt", 72'(err_cnt), 72'(1));
        check("t3_frames", 72'(valid_seen), 72'(1));

        // Reset in the middle of a frame drops the partial data.
        for (int i = 0; i < 5; i++) send(9'(i + 200), 1'b0, 1'b1);
        cycle(1'b0, 9'd0, 1'b0, 1'b1, 1'b1, acc);
        clear_counts();
        for (int i = 0; i < 8; i++) send(9'(-9 + i), 1'b0, 1'b1);
        idle(3, 1'b1);
        check("t4_frames", 72'(valid_seen), 72'(1));
        check("t4_err_cnt", 72'(err_cnt), 72'(0));

        // Continuous streaming with the consumer always ready.
        clear_counts();
        for (int i = 0; i < 32; i++) send(9'(i * 7), 1'b0, 1'b1);
        idle(2, 1'b1);
        check("t5_ready_low", 72'(ready_low), 72'(0));
        check("t5_frames", 72'(valid_seen), 72'(4));

        // Error counter saturation.
        clear_counts();
        for (int i = 0; i < 300; i++) send(9'(i), 1'b1, 1'b1);
        idle(2, 1'b1);
        check("t6_err_pulses", 72'(err_seen), 72'(300));
        check("t6_err_cnt", 72'(err_cnt), 72'(255));
        clear_counts();
        for (int i = 0; i < 8; i++) send(9'(30 + i), 1'b0, 1'b1);
        idle(2, 1'b1);
        check("t6_frames", 72'(valid_seen), 72'(1));

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom % 4) != 0, 9'($urandom), ($urandom % 8) == 0,
                  ($urandom % 3) != 0, ($urandom % 97) == 0, acc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
